// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional-unit output buffer per cycle onto the
// common data bus, with per-requester wait counters for starvation diagnostics.
`timescale 1ns/1ps
module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PTR_WIDTH = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     request,
    input  logic                 rob_ready,
    input  logic                 flush,
    output logic [N_REQ-1:0]     permit,
    output logic                 cdb_valid,
    output logic [PTR_WIDTH-1:0] grant_idx,
    output logic [N_REQ-1:0]     starved
);

    localparam int                   CW        = PTR_WIDTH + 1;
    localparam logic [CW-1:0]        STARVE_TH = CW'(N_REQ);
    localparam logic [CW-1:0]        WAIT_MAX  = '1;
    localparam logic [PTR_WIDTH-1:0] LAST_IDX  = PTR_WIDTH'(N_REQ - 1);

    logic [PTR_WIDTH-1:0] r_ptr;
    logic [CW-1:0]        r_wait [N_REQ];

    logic                 w_found;
    logic                 w_grant;
    logic [PTR_WIDTH-1:0] w_winner;
    int                   w_scan;

    // Scan upward from the pointer, wrapping, and take the first requester seen.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
            if (!w_found && request[w_scan[PTR_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[PTR_WIDTH-1:0];
            end
        end
    end

    // Reset gates the grant directly so a transfer in flight drops the instant reset falls.
    assign w_grant = reset && !flush && rob_ready && w_found;

    always_comb begin
        permit = '0;
        if (w_grant) permit[w_winner] = 1'b1;
        cdb_valid = w_grant;
        grant_idx = w_grant ? w_winner : '0;
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = reset && (r_wait[i] >= STARVE_TH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        end
    end

    // Counters only advance on edges where someone else actually won the bus.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the whole counter array is reset because starved is visible right out of reset.
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!request[i] || permit[i]) begin
                    r_wait[i] <= '0;
                end else if (w_grant && r_wait[i] != WAIT_MAX) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

endmodule
